// File: rtl/life_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : life_pkg
// Purpose  : Shared types and the Game of Life rule for the life_grid engine.
//            cmd_t   - host command encoding (unlisted codes act as NOP)
//            state_t - engine FSM states
//            life_rule(self, count) - next state of one cell
// Revision : 1.0 - initial release
// ============================================================================
package life_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    READ  = 3'd3,
    STEP  = 3'd4
  } cmd_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Birth on exactly 3 live neighbours, survival on 2 or 3.
  function automatic logic life_rule(input logic self, input logic [3:0] count);
    return (count == 4'd3) || ((count == 4'd2) && self);
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_grid_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : life_grid_if
// Purpose  : Host-side bus of the life_grid engine.
//            cmd_valid/cmd_ready/cmd - command handshake
//            row_adr/row_data        - LOAD/READ row and LOAD data
//            step_count              - generations requested by STEP
//            rd_valid/rd_data        - READ result
//            busy/done/gen/alive/stable - status
//            master = host side, slave = engine side.
// Revision : 1.0 - initial release
// ============================================================================
interface life_grid_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) ();
  localparam int AW = $clog2(ROWS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd;
  logic [AW-1:0]    row_adr;
  logic [COLS-1:0]  row_data;
  logic [GEN_W-1:0] step_count;
  logic             rd_valid;
  logic [COLS-1:0]  rd_data;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen;
  logic             alive;
  logic             stable;

  modport master (
    output cmd_valid, cmd, row_adr, row_data, step_count,
    input  cmd_ready, rd_valid, rd_data, busy, done, gen, alive, stable
  );

  modport slave (
    input  cmd_valid, cmd, row_adr, row_data, step_count,
    output cmd_ready, rd_valid, rd_data, busy, done, gen, alive, stable
  );
endinterface
`default_nettype wire

// File: rtl/life_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : life_cell
// Purpose  : One registered Game of Life cell.
//            clk, reset   - clock, synchronous active-high reset
//            i_nbr[7:0]   - states of the eight neighbours
//            i_load_en    - write i_load_val into the cell
//            i_clear      - force the cell dead
//            i_step_en    - advance the cell to o_next
//            o_state      - current state
//            o_next       - next-generation state
// Revision : 1.0 - initial release
// ============================================================================
module life_cell
  import life_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [7:0] i_nbr,
  input  wire logic       i_load_en,
  input  wire logic       i_load_val,
  input  wire logic       i_clear,
  input  wire logic       i_step_en,
  output logic            o_state,
  output logic            o_next
);

  logic       r_state;
  logic [3:0] w_count;

  always_comb begin
    w_count = 4'd0;
    for (int k = 0; k < 8; k++) begin
      w_count = w_count + 4'(i_nbr[k]);
    end
  end

  assign o_next  = life_rule(r_state, w_count);
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_state <= 1'b0;
    end else if (i_load_en) begin
      r_state <= i_load_val;
    end else if (i_step_en) begin
      r_state <= o_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_grid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : life_grid
// Purpose  : ROWS x COLS Game of Life engine with row load/readback and a
//            run-to-completion STEP command that stops early on still life
//            or extinction.
//            clk, reset - clock, synchronous active-high reset
//            bus        - life_grid_if slave port (commands, readback, status)
// Revision : 1.0 - initial release
// ============================================================================
module life_grid
  import life_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input wire logic   clk,
  input wire logic   reset,
  life_grid_if.slave bus
);
  localparam int AW = $clog2(ROWS);

  // Cell (r, c) lives at bit r*COLS + c of the flat vectors.
  logic [ROWS*COLS-1:0] w_cells;
  logic [ROWS*COLS-1:0] w_next_cells;

  state_t           r_state, w_state_nxt;
  logic [GEN_W-1:0] r_remaining, w_rem_nxt;
  logic [GEN_W-1:0] r_gen;
  logic             r_stable;
  logic             r_done, w_done_nxt;
  logic             r_rd_valid;
  logic [COLS-1:0]  r_rd_data;
  logic [COLS-1:0]  w_rd_row;

  cmd_t w_cmd;
  logic w_accept;
  logic w_same;
  logic w_dead;
  logic w_step_en;
  logic w_clear;
  logic w_load;

  assign w_cmd     = cmd_t'(bus.cmd);
  assign w_accept  = bus.cmd_valid && (r_state == IDLE);
  assign w_clear   = w_accept && (w_cmd == CLEAR);
  assign w_load    = w_accept && (w_cmd == LOAD);
  assign w_step_en = (r_state == RUN);
  assign w_same    = (w_next_cells == w_cells);
  assign w_dead    = (w_next_cells == '0);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] w_nbr;

      // Neighbour k: k=0..2 row above (left, mid, right), k=3/4 same row
      // (left, right), k=5..7 row below (left, mid, right).
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                            ((k == 1 || k == 6) ? 0 : 1);
        localparam int WR = (r + DR + ROWS) % ROWS;
        localparam int WC = (c + DC + COLS) % COLS;
        localparam bit INSIDE = (r + DR >= 0) && (r + DR < ROWS) &&
                                (c + DC >= 0) && (c + DC < COLS);
        // Inside the grid the wrapped index equals the plain one, so the
        // same tap serves both edge modes; only off-grid taps differ.
        if ((WRAP != 0) || INSIDE) begin : g_tap
          assign w_nbr[k] = w_cells[WR*COLS + WC];
        end else begin : g_dead
          assign w_nbr[k] = 1'b0;
        end
      end

      life_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .i_nbr      (w_nbr),
        .i_load_en  (w_load && (bus.row_adr == AW'(r))),
        .i_load_val (bus.row_data[c]),
        .i_clear    (w_clear),
        .i_step_en  (w_step_en),
        .o_state    (w_cells[r*COLS + c]),
        .o_next     (w_next_cells[r*COLS + c])
      );
    end
  end

  // Rows at or beyond ROWS match no entry and read back as zero.
  always_comb begin
    w_rd_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (int'(bus.row_adr) == r) begin
        w_rd_row = w_cells[r*COLS +: COLS];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (w_cmd == STEP)) begin
          if (bus.step_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = RUN;
            w_rem_nxt   = bus.step_count;
          end
        end
      end
      RUN: begin
        w_rem_nxt = r_remaining - GEN_W'(1);
        if ((r_remaining == GEN_W'(1)) || w_same || w_dead) begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_gen       <= '0;
      r_stable    <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_done      <= w_done_nxt;
      r_rd_valid  <= w_accept && (w_cmd == READ);
      if (w_accept && (w_cmd == READ)) begin
        r_rd_data <= w_rd_row;
      end
      if (r_state == RUN) begin
        r_gen    <= r_gen + GEN_W'(1);
        r_stable <= w_same;
      end else if (w_clear) begin
        r_gen    <= '0;
        r_stable <= 1'b0;
      end else if (w_load) begin
        r_stable <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = r_done;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.gen       = r_gen;
  assign bus.stable    = r_stable;
  assign bus.alive     = |w_cells;

endmodule
`default_nettype wire

// File: tb/tb_life_grid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_life_grid
// Purpose  : Directed bench for life_grid. dut_a is 16x16 toroidal, dut_b is
//            12x16 with dead edges; sel picks which one the host talks to.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_grid;
  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_CLEAR = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_READ  = 3'd3;
  localparam logic [2:0] C_STEP  = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [3:0]  row_adr = 4'd0;
  logic [15:0] row_data = 16'd0;
  logic [15:0] step_count = 16'd0;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  life_grid_if #(.ROWS(16), .COLS(16), .GEN_W(16)) ifa ();
  life_grid_if #(.ROWS(12), .COLS(16), .GEN_W(16)) ifb ();

  assign ifa.cmd_valid  = cmd_valid & ~sel;
  assign ifa.cmd        = cmd;
  assign ifa.row_adr    = row_adr;
  assign ifa.row_data   = row_data;
  assign ifa.step_count = step_count;
  assign ifb.cmd_valid  = cmd_valid & sel;
  assign ifb.cmd        = cmd;
  assign ifb.row_adr    = row_adr;
  assign ifb.row_data   = row_data;
  assign ifb.step_count = step_count;

  life_grid #(.COLS(16), .ROWS(16), .WRAP(1), .GEN_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  life_grid #(.COLS(16), .ROWS(12), .WRAP(0), .GEN_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  logic        w_ready, w_busy, w_done, w_rd_valid, w_alive, w_stable;
  logic [15:0] w_rd_data, w_gen;
  assign w_ready    = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign w_busy     = sel ? ifb.busy      : ifa.busy;
  assign w_done     = sel ? ifb.done      : ifa.done;
  assign w_rd_valid = sel ? ifb.rd_valid  : ifa.rd_valid;
  assign w_rd_data  = sel ? ifb.rd_data   : ifa.rd_data;
  assign w_gen      = sel ? ifb.gen       : ifa.gen;
  assign w_alive    = sel ? ifb.alive     : ifa.alive;
  assign w_stable   = sel ? ifb.stable    : ifa.stable;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called mid-cycle; returns mid-cycle in the cycle after acceptance.
  task automatic issue(input logic [2:0] c, input logic [3:0] a,
                       input logic [15:0] d, input logic [15:0] n);
    cmd = c; row_adr = a; row_data = d; step_count = n; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = C_NOP;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    issue(C_READ, a, 16'd0, 16'd0);
    check({tag, "_vld"}, 32'(w_rd_valid), 32'd1);
    check(tag, 32'(w_rd_data), 32'(exp));
  endtask

  // Returns in the done cycle with the number of busy cycles seen.
  task automatic run_step(input logic [15:0] n, output int cycles);
    issue(C_STEP, 4'd0, 16'd0, n);
    cycles = 0;
    while (w_busy && cycles < 1000) begin
      cycles++;
      @(posedge clk); #1;
    end
    check("done_pulse", 32'(w_done), 32'd1);
    check("ready_at_done", 32'(w_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset state (dut_a) ----
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_ready", 32'(w_ready), 32'd1);
    check("rst_busy", 32'(w_busy), 32'd0);
    check("rst_gen", 32'(w_gen), 32'd0);
    check("rst_alive", 32'(w_alive), 32'd0);
    check("rst_done", 32'(w_done), 32'd0);
    check("rst_stable", 32'(w_stable), 32'd0);
    check("rst_rdv", 32'(w_rd_valid), 32'd0);
    check("rst_rdd", 32'(w_rd_data), 32'd0);

    // ---- blinker, one generation ----
    issue(C_LOAD, 4'd7, 16'h0380, 16'd0);
    check("blk_alive", 32'(w_alive), 32'd1);
    run_step(16'd1, cyc);
    check("blk_busy_cyc", 32'(cyc), 32'd1);
    check("blk_gen", 32'(w_gen), 32'd1);
    check("blk_stable", 32'(w_stable), 32'd0);
    // Read issued in the done cycle, so it is accepted there.
    read_chk("blk_r6", 4'd6, 16'h0100);
    check("done_one_cycle", 32'(w_done), 32'd0);
    read_chk("blk_r7", 4'd7, 16'h0100);
    read_chk("blk_r8", 4'd8, 16'h0100);
    read_chk("blk_r5", 4'd5, 16'h0000);

    // ---- block still life: early stop ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    check("clr_gen", 32'(w_gen), 32'd0);
    check("clr_alive", 32'(w_alive), 32'd0);
    issue(C_LOAD, 4'd4, 16'h0018, 16'd0);
    issue(C_LOAD, 4'd5, 16'h0018, 16'd0);
    run_step(16'd10, cyc);
    check("still_cyc", 32'(cyc), 32'd1);
    check("still_stable", 32'(w_stable), 32'd1);
    check("still_gen", 32'(w_gen), 32'd1);
    read_chk("still_r4", 4'd4, 16'h0018);
    read_chk("still_r5", 4'd5, 16'h0018);
    issue(C_LOAD, 4'd0, 16'h0000, 16'd0);
    check("load_clr_stable", 32'(w_stable), 32'd0);
    check("load_keep_gen", 32'(w_gen), 32'd1);

    // ---- extinction ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd10, 16'h0400, 16'd0);
    run_step(16'd5, cyc);
    check("ext_cyc", 32'(cyc), 32'd1);
    check("ext_alive", 32'(w_alive), 32'd0);
    check("ext_gen", 32'(w_gen), 32'd1);

    // ---- glider on the torus returns home after 64 generations ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd1, 16'h0002, 16'd0);
    issue(C_LOAD, 4'd2, 16'h0004, 16'd0);
    issue(C_LOAD, 4'd3, 16'h0007, 16'd0);
    run_step(16'd64, cyc);
    check("gl_cyc", 32'(cyc), 32'd64);
    check("gl_gen", 32'(w_gen), 32'd64);
    check("gl_stable", 32'(w_stable), 32'd0);
    read_chk("gl_r0", 4'd0, 16'h0000);
    read_chk("gl_r1", 4'd1, 16'h0002);
    read_chk("gl_r2", 4'd2, 16'h0004);
    read_chk("gl_r3", 4'd3, 16'h0007);
    read_chk("gl_r4", 4'd4, 16'h0000);

    // ---- corner blinker across both wrap seams ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd0, 16'h8003, 16'd0);
    run_step(16'd1, cyc);
    read_chk("wr_r15", 4'd15, 16'h0001);
    read_chk("wr_r0", 4'd0, 16'h0001);
    read_chk("wr_r1", 4'd1, 16'h0001);
    read_chk("wr_r14", 4'd14, 16'h0000);

    // ---- command held while busy is not taken ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd7, 16'h0380, 16'd0);
    issue(C_STEP, 4'd0, 16'd0, 16'd20);
    cmd = C_LOAD; row_adr = 4'd0; row_data = 16'hFFFF; cmd_valid = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      check("hs_ready_busy", 32'(w_ready), 32'd0);
      cyc++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; cmd = C_NOP;
    while (w_busy && cyc < 1000) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("hs_cyc", 32'(cyc), 32'd20);
    check("hs_done", 32'(w_done), 32'd1);
    check("hs_gen", 32'(w_gen), 32'd20);
    read_chk("hs_r0", 4'd0, 16'h0000);
    read_chk("hs_r7", 4'd7, 16'h0380);

    // ---- reset in RUN cycle 5 ----
    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd7, 16'h0380, 16'd0);
    issue(C_STEP, 4'd0, 16'd0, 16'd20);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_gen", 32'(w_gen), 32'd4);
    check("mid_busy", 32'(w_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rr_busy", 32'(w_busy), 32'd0);
    check("rr_ready", 32'(w_ready), 32'd1);
    check("rr_gen", 32'(w_gen), 32'd0);
    check("rr_done", 32'(w_done), 32'd0);
    check("rr_alive", 32'(w_alive), 32'd0);
    @(posedge clk); #1;
    check("rr_no_late_done", 32'(w_done), 32'd0);
    read_chk("rr_r7", 4'd7, 16'h0000);

    // ---- dut_b: 12 rows, dead edges ----
    sel = 1'b1;
    issue(C_LOAD, 4'd13, 16'hFFFF, 16'd0);
    check("b_oor_load", 32'(w_alive), 32'd0);
    read_chk("b_oor_read", 4'd13, 16'h0000);
    issue(C_LOAD, 4'd11, 16'h1234, 16'd0);
    check("b_alive", 32'(w_alive), 32'd1);
    read_chk("b_r11", 4'd11, 16'h1234);
    run_step(16'd0, cyc);
    check("b_step0_cyc", 32'(cyc), 32'd0);
    check("b_step0_gen", 32'(w_gen), 32'd0);
    read_chk("b_step0_r11", 4'd11, 16'h1234);

    issue(C_CLEAR, 4'd0, 16'd0, 16'd0);
    issue(C_LOAD, 4'd0, 16'h0007, 16'd0);
    issue(C_LOAD, 4'd11, 16'hE000, 16'd0);
    run_step(16'd1, cyc);
    check("b_edge_gen", 32'(w_gen), 32'd1);
    read_chk("b_e_r0", 4'd0, 16'h0002);
    read_chk("b_e_r1", 4'd1, 16'h0002);
    read_chk("b_e_r2", 4'd2, 16'h0000);
    read_chk("b_e_r9", 4'd9, 16'h0000);
    read_chk("b_e_r10", 4'd10, 16'h4000);
    read_chk("b_e_r11", 4'd11, 16'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
